// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/port enums and widths for the memory port arbiter
package mem_arb_pkg;
  localparam int ARB_DATA_W = 32;
  localparam int MASK_W = ARB_DATA_W / 8;
  typedef enum logic [2:0] {IDLE, GRANT_IF, GRANT_LSU, DONE_IF, DONE_LSU} arb_state_e;
  typedef enum logic {PORT_IF, PORT_LSU} port_id_e;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: saturating wait-state counter; expire fires on the MAX_WAIT-th enabled cycle
module mem_arb_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && cnt != CW'(MAX_WAIT)) cnt <= cnt + CW'(1);
  end
  assign expire = en && cnt == CW'(MAX_WAIT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between IF and LSU ports with held handshake and timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_mask,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall_if_mem,
  output logic                stall_lsu_mem,
  output logic                err_timeout
);
  arb_state_e state, nxt;
  logic in_grant, expire, lsu_win;
  assign in_grant = state == GRANT_IF || state == GRANT_LSU;
  mem_arb_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk), .rst(rst), .clr(!in_grant), .en(in_grant && !mem_ready), .expire(expire)
  );
`ifdef MEM_ARB_RR_EN
  port_id_e rr_last;
  always_ff @(posedge clk) begin
    if (rst) rr_last <= PORT_IF;
    else if (state == DONE_IF) rr_last <= PORT_IF;
    else if (state == DONE_LSU) rr_last <= PORT_LSU;
  end
  assign lsu_win = lsu_req && (!if_req || rr_last == PORT_IF);
`else
  assign lsu_win = lsu_req;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = lsu_win ? GRANT_LSU : if_req ? GRANT_IF : IDLE;
      GRANT_IF:  nxt = (mem_ready || expire) ? DONE_IF : GRANT_IF;
      GRANT_LSU: nxt = (mem_ready || expire) ? DONE_LSU : GRANT_LSU;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_mask    <= '0;
      if_rdata    <= '0;
      lsu_rdata   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == GRANT_LSU) begin
        mem_we    <= lsu_we;
        mem_addr  <= lsu_addr;
        mem_wdata <= lsu_wdata;
        mem_mask  <= lsu_mask;
      end else if (state == IDLE && nxt == GRANT_IF) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_mask  <= '1;
      end
      // a timed-out read returns zero; stores never touch lsu_rdata
      if (state == GRANT_IF && (mem_ready || expire)) if_rdata <= mem_ready ? mem_rdata : '0;
      if (state == GRANT_LSU && !mem_we && (mem_ready || expire)) lsu_rdata <= mem_ready ? mem_rdata : '0;
      if (expire) err_timeout <= 1'b1;
    end
  end
  assign mem_req       = in_grant;
  assign if_ack        = state == DONE_IF;
  assign lsu_ack       = state == DONE_LSU;
  assign stall_if_mem  = if_req && !if_ack;
  assign stall_lsu_mem = lsu_req && !lsu_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, if_ack, lsu_req = 1'b0, lsu_we = 1'b0, lsu_ack;
  logic [31:0] if_addr = '0, if_rdata, lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
  logic [3:0] lsu_mask = '0, mem_mask;
  logic mem_req, mem_we, mem_ready = 1'b0, stall_if_mem, stall_lsu_mem, err_timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  int errors = 0, checks = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
    .lsu_rdata(lsu_rdata), .lsu_ack(lsu_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if_mem(stall_if_mem), .stall_lsu_mem(stall_lsu_mem), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if ({mem_req, mem_we, if_ack, lsu_ack, err_timeout} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_req, mem_we, if_ack, lsu_ack, err_timeout}); end
    checks++; if ({mem_addr, mem_wdata, mem_mask, if_rdata, lsu_rdata} !== 132'b0) begin errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, mem_mask, if_rdata, lsu_rdata}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    checks++; if (stall_if_mem !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL if_idle got stall=%b req=%b exp 1 0", stall_if_mem, mem_req); end
    step();
    checks++; if ({mem_req, mem_we, mem_mask} !== 6'b10_1111 || mem_addr !== 32'h40) begin errors++; $display("FAIL if_grant got req=%b we=%b mask=%h addr=%h exp 1 0 f 40", mem_req, mem_we, mem_mask, mem_addr); end
    checks++; if (stall_if_mem !== 1'b1) begin errors++; $display("FAIL if_stall got %b exp 1", stall_if_mem); end
    mem_ready = 1'b1; mem_rdata = 32'h13;
    step();
    checks++; if (if_ack !== 1'b1 || mem_req !== 1'b0 || if_rdata !== 32'h13 || stall_if_mem !== 1'b0) begin errors++; $display("FAIL if_ack got ack=%b req=%b rdata=%h stall=%b exp 1 0 13 0", if_ack, mem_req, if_rdata, stall_if_mem); end
    if_req = 1'b0; mem_ready = 1'b0;
    step();
    checks++; if (if_ack !== 1'b0 || if_rdata !== 32'h13) begin errors++; $display("FAIL if_hold got ack=%b rdata=%h exp 0 13", if_ack, if_rdata); end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h44;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h100; lsu_wdata = 32'hDEAD_BEEF; lsu_mask = 4'b0011;
    step();
    checks++; if ({mem_req, mem_we, mem_mask} !== 6'b11_0011 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prio_lsu got req=%b we=%b mask=%h addr=%h wdata=%h", mem_req, mem_we, mem_mask, mem_addr, mem_wdata); end
    mem_ready = 1'b1; mem_rdata = 32'h55;
    step();
    checks++; if (lsu_ack !== 1'b1 || if_ack !== 1'b0 || stall_if_mem !== 1'b1) begin errors++; $display("FAIL prio_ack got lsu_ack=%b if_ack=%b stall_if=%b exp 1 0 1", lsu_ack, if_ack, stall_if_mem); end
    checks++; if (lsu_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got %h exp 0", lsu_rdata); end
    lsu_req = 1'b0; mem_ready = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0 || stall_if_mem !== 1'b1) begin errors++; $display("FAIL prio_bubble got req=%b stall_if=%b exp 0 1", mem_req, stall_if_mem); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h44 || mem_mask !== 4'hF) begin errors++; $display("FAIL prio_if got req=%b we=%b addr=%h mask=%h exp 1 0 44 f", mem_req, mem_we, mem_addr, mem_mask); end
    mem_ready = 1'b1; mem_rdata = 32'h77;
    step();
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h77) begin errors++; $display("FAIL prio_if_ack got ack=%b rdata=%h exp 1 77", if_ack, if_rdata); end
    if_req = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_wait_states();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h200; lsu_mask = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || lsu_ack !== 1'b0 || stall_lsu_mem !== 1'b1) begin errors++; $display("FAIL wait_cycle%0d got req=%b addr=%h ack=%b stall=%b", i, mem_req, mem_addr, lsu_ack, stall_lsu_mem); end
      if (i == 5) begin mem_ready = 1'b1; mem_rdata = 32'hCAFE; end
    end
    step();
    checks++; if (lsu_ack !== 1'b1 || lsu_rdata !== 32'hCAFE || err_timeout !== 1'b0) begin errors++; $display("FAIL wait_ack got ack=%b rdata=%h err=%b exp 1 cafe 0", lsu_ack, lsu_rdata, err_timeout); end
    lsu_req = 1'b0; mem_ready = 1'b0;
    step();
    checks++; if (lsu_ack !== 1'b0) begin errors++; $display("FAIL wait_pulse got %b exp 0", lsu_ack); end
  endtask

  task automatic test_timeout();
    if_req = 1'b1; if_addr = 32'h80;
    for (int i = 0; i < 15; i++) begin
      step();
      checks++; if (mem_req !== 1'b1 || err_timeout !== 1'b0 || if_ack !== 1'b0) begin errors++; $display("FAIL to_wait%0d got req=%b err=%b ack=%b exp 1 0 0", i, mem_req, err_timeout, if_ack); end
    end
    step();
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0 || err_timeout !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL to_expire got ack=%b rdata=%h err=%b req=%b exp 1 0 1 0", if_ack, if_rdata, err_timeout, mem_req); end
    if_req = 1'b0;
    step();
    step();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", err_timeout); end
    rst = 1'b1;
    step();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", err_timeout); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'hC0;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_grant got %b exp 1", mem_req); end
    rst = 1'b1;
    step();
    checks++; if (mem_req !== 1'b0 || if_ack !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL rm_abandon got req=%b ack=%b rdata=%h exp 0 0 0", mem_req, if_ack, if_rdata); end
    rst = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hC0) begin errors++; $display("FAIL rm_regrant got req=%b addr=%h exp 1 c0", mem_req, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h99;
    step();
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h99) begin errors++; $display("FAIL rm_ack got ack=%b rdata=%h exp 1 99", if_ack, if_rdata); end
    if_req = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    if_req = 1'b1; if_addr = 32'h400;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h300; lsu_mask = 4'hF;
    mem_ready = 1'b1; mem_rdata = 32'h1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_addr = (i % 2 == 0) ? 32'h300 : 32'h400;
`else
      exp_addr = 32'h300;
`endif
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL b2b_grant%0d got req=%b addr=%h exp 1 %h", i, mem_req, mem_addr, exp_addr); end
      step();
      checks++; if (lsu_ack !== (exp_addr == 32'h300) || if_ack !== (exp_addr == 32'h400) || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_ack%0d got lsu=%b if=%b req=%b", i, lsu_ack, if_ack, mem_req); end
      step();
      checks++; if (mem_req !== 1'b0 || lsu_ack !== 1'b0 || if_ack !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d got req=%b lsu=%b if=%b exp 0 0 0", i, mem_req, lsu_ack, if_ack); end
    end
    if_req = 1'b0; lsu_req = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF fetch port and the MW load/store port of the 3-stage pipeline.
- Converts each requester's level request into a held memory transaction with a valid/ready handshake.
- Returns a one-cycle ack with read data to the winning requester.
- Drives per-port stall requests that the hazard logic ORs into stall_if and stall_dx.
- Watches each transaction with a wait-state timeout.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; mask width is DATA_W/8
- MAX_WAIT, 15, maximum cycles mem_req may stay high without mem_ready before timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request (level)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid when if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- lsu_req  in  1  load/store request (level)
- lsu_we  in  1  1 = store
- lsu_addr  in  ADDR_W  load/store address
- lsu_wdata  in  DATA_W  store data
- lsu_mask  in  DATA_W/8  byte enables
- lsu_rdata  out  DATA_W  load data, valid when lsu_ack=1
- lsu_ack  out  1  one-cycle load/store completion pulse
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_mask  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory accept/complete, single-cycle
- stall_if_mem  out  1  fetch port waiting
- stall_lsu_mem  out  1  load/store port waiting
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset values (synchronous, active-high, applied at the next clk edge):
  - mem_req, mem_we, if_ack, lsu_ack, err_timeout = 0.
  - mem_addr, mem_wdata, mem_mask, if_rdata, lsu_rdata = 0.
  - state = IDLE; wait counter = 0; rr_last = IF.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and mem_req is 0 in the cycle after reset.
- States:
  - IDLE -> GRANT_LSU when lsu_req=1.
  - IDLE -> GRANT_IF when only if_req=1.
  - GRANT_x -> DONE_x when mem_ready=1.
  - DONE_x -> IDLE unconditionally.
- Arbitration:
  - Priority is fixed: LSU beats IF, so the older instruction in MW always progresses.
  - A grant is evaluated only in IDLE. A request arriving during a transaction waits; no preemption.
- GRANT_x entry (registered):
  - mem_req=1, and mem_addr/mem_we/mem_wdata/mem_mask are captured from the winning port.
  - These stay stable until mem_ready=1.
  - For IF grants, mem_we=0 and mem_mask is all ones.
- On mem_ready=1 in GRANT_x:
  - mem_rdata is registered into x_rdata.
  - The x_ack pulse is driven in DONE_x, exactly one cycle.
  - mem_req drops to 0 in DONE_x.
- Latency: a request seen in IDLE at cycle N gives mem_req=1 at N+1. With mem_ready at N+1, the ack comes at N+2. The minimum turnaround is 3 cycles per access, including the DONE bubble.
- x_rdata holds its value until the next ack for that port. Store acks leave lsu_rdata unchanged.
- Stall outputs are combinational: stall_if_mem = if_req & ~if_ack, and stall_lsu_mem = lsu_req & ~lsu_ack.
- Requesters hold req and payload until ack. If a requester drops req mid-transaction, the transaction still completes and the ack still pulses; the requester ignores it.
- Back-to-back: in DONE_x a pending request for either port is not granted until IDLE, so a port cannot issue two consecutive accesses without an IDLE cycle.
- Timeout:
  - The wait counter counts cycles in GRANT_x with mem_ready=0, saturating at MAX_WAIT.
  - On reaching MAX_WAIT, err_timeout sets (sticky until rst) and the state goes to DONE_x. The ack still pulses, with x_rdata = 0.
  - The counter clears on every GRANT entry.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Arbitration in IDLE is round-robin. When both requests are high, the port not served last (rr_last) wins.
  - rr_last updates on every DONE_x.
- Not defined: fixed LSU priority, and the rr_last register is not instantiated.

Decomposition:
- Package mem_arb_pkg:
  - Enum arb_state_e {IDLE, GRANT_IF, GRANT_LSU, DONE_IF, DONE_LSU}.
  - Port-id enum {PORT_IF, PORT_LSU}.
  - Localparam MASK_W = DATA_W/8.
- One sub-module, mem_arb_timer: the saturating wait counter with clear/enable inputs and an expire output.

Test Plan:
- Only if_req=1, if_addr=0x0000_0040, mem_ready=1 on first mem_req cycle, mem_rdata=0x0000_0013 -> mem_req high 1 cycle with mem_we=0 and mem_mask=4'hF; if_ack one cycle later; if_rdata=0x0000_0013; stall_if_mem high until the ack.
- if_req and lsu_req both high in the same cycle, lsu_we=1, lsu_addr=0x100, lsu_wdata=0xDEAD_BEEF, lsu_mask=4'b0011 -> LSU served first with mem_mask=4'b0011; IF granted after the IDLE cycle; stall_if_mem held throughout.
- LSU load with mem_ready withheld 5 cycles -> mem_addr/mem_req stable for 6 cycles; lsu_ack exactly one cycle; err_timeout stays 0.
- mem_ready never asserted, MAX_WAIT=15 -> err_timeout=1 after 15 wait cycles; ack pulses with rdata=0; flag stays set until rst.
- rst asserted during GRANT_IF -> next cycle mem_req=0 and no if_ack; a fresh if_req completes normally afterwards.
- With MEM_ARB_RR_EN, both requests held continuously for 4 accesses -> grants alternate LSU, IF, LSU, IF.
